// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its branch target buffer.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package fetch_pkg;

    // Two-bit saturating direction counter; bit 1 is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Counters start weakly not-taken so one taken resolution flips them.
    localparam ctr_t        CTR_RESET = WNT;

    // Sequential fetch advances one 32-bit instruction.
    localparam logic [31:0] PC_INC    = 32'd4;

    // Saturating counter step: up on taken, down on not-taken.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) begin
                nxt = ctr_t'(cur + 2'd1);
            end
        end else begin
            if (cur != SNT) begin
                nxt = ctr_t'(cur - 2'd1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_unit_btb_table.sv
// Branch target buffer: valid/tag/target per PC index plus a direction counter array.
// Latency: read port is combinational; writes take effect at the next clock edge.
// Backpressure: none; a write is accepted every cycle wr_vld_i is high (reset wins).
module btb_table
    import fetch_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = 5,
    parameter int TAG_W   = 25
) (
    input  logic             clk,
    input  logic             reset,
    // read port
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [IDX_W-1:0] rd_ctr_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_target_o,
    output logic [1:0]       rd_ctr_o,
    // write port
    input  logic             wr_vld_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [IDX_W-1:0] wr_ctr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_taken_i,
    input  logic [31:0]      wr_target_i
);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];

    ctr_t             ctr_upd_d;

    // Reads see the table as it stood before this cycle's write.
    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_ctr_idx_i];

    // Next value of the counter selected by the write port.
    always_comb begin
        ctr_upd_d = ctr_next(ctr_q[wr_ctr_idx_i], wr_taken_i);
    end

    // Valid bits and counters: cleared on reset, which also drops a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (wr_vld_i) begin
            ctr_q[wr_ctr_idx_i] <= ctr_upd_d;
            if (wr_taken_i) begin
                valid_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    // Tag/target payload: only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_vld_i && wr_taken_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC generation with BTB/2-bit-counter next-PC prediction; GSHARE_EN adds global history.
// Latency: pred_* combinational from current_pc; redirect reaches current_pc one cycle later.
// Backpressure: stall holds current_pc; redirect overrides stall; resolutions always apply.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int BTB_ENTRIES = 32,
    parameter int GHR_BITS    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    output logic [31:0] current_pc,
    output logic [31:0] pred_next_pc,
    output logic        pred_taken
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;

    logic [IDX-1:0]   lk_idx;
    logic [IDX-1:0]   lk_ctr_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX-1:0]   up_idx;
    logic [IDX-1:0]   up_ctr_idx;
    logic [TAG_W-1:0] up_tag;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_target;
    logic [1:0]       rd_ctr;

    logic             unused_upd_lo;

    assign lk_idx = pc_q[IDX+1:2];
    assign lk_tag = pc_q[31:IDX+2];
    assign up_idx = update_pc[IDX+1:2];
    assign up_tag = update_pc[31:IDX+2];

    // Instructions are word aligned; the low address bits never reach the tables.
    assign unused_upd_lo = ^update_pc[1:0];

`ifdef GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;
    logic [IDX-1:0]      ghr_ext;

    // Lookup and update both hash with the history as it stood before this cycle's shift.
    assign ghr_ext    = IDX'(ghr_q);
    assign lk_ctr_idx = lk_idx ^ ghr_ext;
    assign up_ctr_idx = up_idx ^ ghr_ext;

    // Shift the resolved direction into the history on every resolution.
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid) begin
            ghr_d = GHR_BITS'({ghr_q, update_taken});
        end
    end

    // Global history register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic [GHR_BITS-1:0] unused_ghr_cfg;

    // Without history the counters share the BTB index.
    assign lk_ctr_idx     = lk_idx;
    assign up_ctr_idx     = up_idx;
    assign unused_ghr_cfg = '0;
`endif

    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .rd_idx_i     (lk_idx),
        .rd_ctr_idx_i (lk_ctr_idx),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_target_o  (rd_target),
        .rd_ctr_o     (rd_ctr),
        .wr_vld_i     (update_valid),
        .wr_idx_i     (up_idx),
        .wr_ctr_idx_i (up_ctr_idx),
        .wr_tag_i     (up_tag),
        .wr_taken_i   (update_taken),
        .wr_target_i  (update_target)
    );

    // Prediction depends only on current_pc and stored state, never on the update inputs.
    always_comb begin
        pred_taken   = rd_valid && (rd_tag == lk_tag) && rd_ctr[1];
        pred_next_pc = pred_taken ? rd_target : (pc_q + PC_INC);
    end

    // Next fetch address: redirect beats stall beats prediction.
    always_comb begin
        pc_d = pred_next_pc;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign current_pc = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected outputs, a negedge monitor compares.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [31:0] current_pc;
    logic [31:0] pred_next_pc;
    logic        pred_taken;

    typedef struct packed {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] npc;
        logic        chk_ghr;
        logic [7:0]  ghr;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    exp_t  mon_e;
    string mon_nm;
    int    n_cmp = 0;
    int    n_err = 0;

    fetch_unit #(.BTB_ENTRIES(32), .GHR_BITS(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .current_pc    (current_pc),
        .pred_next_pc  (pred_next_pc),
        .pred_taken    (pred_taken)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e  = sb_q.pop_front();
            mon_nm = nm_q.pop_front();
            cmp(mon_nm, "current_pc", current_pc, mon_e.pc);
            cmp(mon_nm, "pred_taken", {31'd0, pred_taken}, {31'd0, mon_e.pt});
            cmp(mon_nm, "pred_next_pc", pred_next_pc, mon_e.npc);
`ifdef GSHARE_EN
            if (mon_e.chk_ghr) begin
                cmp(mon_nm, "ghr", {27'd0, dut.ghr_q}, {24'd0, mon_e.ghr});
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_g(input string nm, input logic [31:0] pc, input logic pt,
                            input logic [31:0] npc, input logic chk_ghr, input logic [7:0] ghr);
        exp_t e;
        e.pc      = pc;
        e.pt      = pt;
        e.npc     = npc;
        e.chk_ghr = chk_ghr;
        e.ghr     = ghr;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic expect_out(input string nm, input logic [31:0] pc, input logic pt, input logic [31:0] npc);
        expect_g(nm, pc, pt, npc, 1'b0, 8'd0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_taken  = taken;
        update_target = tgt;
    endtask

    // One-cycle redirect to pc, leaving current_pc == pc afterwards.
    task automatic jump(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;

        // Reset and free-running sequential fetch
        step(); step();
        reset = 1'b0;
        expect_g("reset", 32'h0, 1'b0, 32'h4, 1'b1, 8'd0);
        step(); expect_out("free_4", 32'h4, 1'b0, 32'h8);
        step(); expect_out("free_8", 32'h8, 1'b0, 32'hC);
        step(); expect_out("free_12", 32'hC, 1'b0, 32'h10);

`ifndef GSHARE_EN
        // Taken resolution installs 0x10 -> 0x40 and makes the counter WT
        upd(32'h10, 1'b1, 32'h40);
        step(); update_valid = 1'b0;
        expect_out("bt_hit", 32'h10, 1'b1, 32'h40);
        step(); expect_out("bt_jump", 32'h40, 1'b0, 32'h44);

        // Two not-taken resolutions under stall: counter WT -> SNT, PC held
        stall = 1'b1;
        upd(32'h10, 1'b0, 32'h300);
        step(); expect_out("stall_hold", 32'h40, 1'b0, 32'h44);
        step(); update_valid = 1'b0; stall = 1'b0;
        jump(32'h10);
        expect_out("nt_cnt", 32'h10, 1'b0, 32'h14);

        // Redirect wins over stall, then stall alone holds
        stall = 1'b1;
        jump(32'h200);
        expect_out("stall_redir", 32'h200, 1'b0, 32'h204);
        step(); expect_out("stall_only", 32'h200, 1'b0, 32'h204);

        // Extra not-taken at SNT must saturate
        upd(32'h10, 1'b0, 32'h0);
        step(); update_valid = 1'b0; stall = 1'b0;
        jump(32'h10);

        // Same-cycle lookup and update at 0x10 sees the old counter
        upd(32'h10, 1'b1, 32'h80);
        expect_out("same_cyc", 32'h10, 1'b0, 32'h14);
        step(); update_valid = 1'b0;
        expect_out("after_upd", 32'h14, 1'b0, 32'h18);
        jump(32'h10);
        expect_out("lo_sat", 32'h10, 1'b0, 32'h14);

        // 0x10 and 0x90 share index 4; the later taken resolution owns the tag
        stall = 1'b1;
        upd(32'h10, 1'b1, 32'h40);
        step();
        upd(32'h90, 1'b1, 32'h100);
        step(); update_valid = 1'b0; stall = 1'b0;
        jump(32'h90);
        expect_out("alias_hit", 32'h90, 1'b1, 32'h100);
        step(); expect_out("alias_jump", 32'h100, 1'b0, 32'h104);
        jump(32'h10);
        expect_out("alias_miss", 32'h10, 1'b0, 32'h14);

        // Taken at ST must saturate: one not-taken afterwards still predicts taken
        stall = 1'b1;
        upd(32'h90, 1'b1, 32'h100);
        step();
        upd(32'h90, 1'b0, 32'h0);
        step(); update_valid = 1'b0; stall = 1'b0;
        jump(32'h90);
        expect_out("hi_sat", 32'h90, 1'b1, 32'h100);

        // Reset mid-operation drops the concurrent update and clears the table
        reset = 1'b1;
        upd(32'h20, 1'b1, 32'h300);
        step(); reset = 1'b0; update_valid = 1'b0;
        expect_out("rst_mid", 32'h0, 1'b0, 32'h4);
        jump(32'h20);
        expect_out("rst_drop", 32'h20, 1'b0, 32'h24);
        jump(32'h90);
        expect_out("rst_clr", 32'h90, 1'b0, 32'h94);
`else
        // History T,T,N gives 00110; 0x10 then uses counter 4^6=2 (still WNT)
        stall = 1'b1;
        upd(32'h10, 1'b1, 32'h40);
        step();
        upd(32'h10, 1'b1, 32'h40);
        step();
        upd(32'h10, 1'b0, 32'h40);
        step(); update_valid = 1'b0; stall = 1'b0;
        jump(32'h10);
        expect_g("gshare", 32'h10, 1'b0, 32'h14, 1'b1, 8'h06);
`endif

        // Sequential increment wraps modulo 2^32
        jump(32'hFFFF_FFFC);
        expect_out("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        step(); expect_out("wrap_pc", 32'h0, 1'b0, 32'h4);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
